// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer.
// Owns the instruction register and walks each instruction through IF/ID/EX/MEM/WB,
// driving per-state datapath controls and a req/ready handshake to instruction and
// data memory. A stalled handshake ends in the absorbing ERR state; an unsupported
// instruction ends in the absorbing TRAP state when EXC_EN is set.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 8,
    parameter bit          EXC_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] ir,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [3:0]  aluop,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        bus_err,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StErr  = 3'd5,
        StTrap = 3'd6
    } state_e;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnSlt  = 6'h2A;

    // ALU operations
    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluOr  = 4'd3;
    localparam logic [3:0] AluSlt = 4'd4;
    localparam logic [3:0] AluLui = 4'd5;

    // ALU B-operand selects
    localparam logic [1:0] SrcRt   = 2'd0;
    localparam logic [1:0] SrcSext = 2'd1;
    localparam logic [1:0] SrcZext = 2'd2;

    // PC source selects
    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcJump   = 2'd2;
    localparam logic [1:0] PcRs     = 2'd3;

    // Register destination and write-back selects
    localparam logic [1:0] DstRt  = 2'd0;
    localparam logic [1:0] DstRd  = 2'd1;
    localparam logic [1:0] DstRa  = 2'd2;
    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbMem  = 2'd1;
    localparam logic [1:0] WbLink = 2'd2;

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            illegal_q, illegal_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_nop, is_r_alu, is_jr, is_i_alu, is_lw, is_sw;
    logic       is_beq, is_bne, is_j, is_jal, is_legal;
    logic [3:0] alu_fn;
    logic [1:0] src_b_sel;
    logic       timed_out;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // Classify the latched instruction; a zero word is a NOP ahead of any other decode
    always_comb begin
        is_nop    = 1'b0;
        is_r_alu  = 1'b0;
        is_jr     = 1'b0;
        is_i_alu  = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        alu_fn    = AluAdd;
        src_b_sel = SrcRt;
        if (ir_q == 32'd0) begin
            is_nop = 1'b1;
        end else begin
            case (opcode)
                OpRtype: begin
                    case (funct)
                        FnAddu:  begin is_r_alu = 1'b1; alu_fn = AluAdd; end
                        FnSubu:  begin is_r_alu = 1'b1; alu_fn = AluSub; end
                        FnAnd:   begin is_r_alu = 1'b1; alu_fn = AluAnd; end
                        FnOr:    begin is_r_alu = 1'b1; alu_fn = AluOr;  end
                        FnSlt:   begin is_r_alu = 1'b1; alu_fn = AluSlt; end
                        FnJr:    is_jr = 1'b1;
                        default: ;
                    endcase
                end
                OpAddiu: begin is_i_alu = 1'b1; alu_fn = AluAdd; src_b_sel = SrcSext; end
                OpOri:   begin is_i_alu = 1'b1; alu_fn = AluOr;  src_b_sel = SrcZext; end
                OpLui:   begin is_i_alu = 1'b1; alu_fn = AluLui; src_b_sel = SrcSext; end
                OpLw:    is_lw  = 1'b1;
                OpSw:    is_sw  = 1'b1;
                OpBeq:   is_beq = 1'b1;
                OpBne:   is_bne = 1'b1;
                OpJ:     is_j   = 1'b1;
                OpJal:   is_jal = 1'b1;
                default: ;
            endcase
        end
    end

    assign is_legal = is_r_alu | is_jr | is_i_alu | is_lw | is_sw |
                      is_beq | is_bne | is_j | is_jal;

    // A ready seen on the cycle the count hits the limit still wins over the timeout
    assign timed_out = (cnt_q == TO_W'(MEM_TIMEOUT));

    // Next-state, instruction latch, wait counter and sticky flags
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIf: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StId;
                end else if (timed_out) begin
                    state_d   = StErr;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StId: begin
                if (is_nop) begin
                    state_d = StIf;
                end else if (!is_legal) begin
                    if (EXC_EN) begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = StIf;
                    end
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                if (is_lw || is_sw) begin
                    state_d = StMem;
                end else if (is_r_alu || is_i_alu) begin
                    state_d = StWb;
                end else begin
                    state_d = StIf;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = is_lw ? StWb : StIf;
                end else if (timed_out) begin
                    state_d   = StErr;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StWb:    state_d = StIf;
            StErr:   state_d = StErr;
            StTrap:  state_d = StTrap;
            default: state_d = StIf;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIf;
            ir_q      <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    // Per-state datapath controls; everything is held at zero while in reset
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PcPlus4;
        aluop     = AluAdd;
        alu_src_b = SrcRt;
        reg_write = 1'b0;
        reg_dst   = DstRt;
        wb_sel    = WbAlu;
        if (!rst) begin
            unique case (state_q)
                StIf: begin
                    imem_req = 1'b1;
                    pc_write = imem_ready;
                    pc_src   = PcPlus4;
                end
                StEx: begin
                    if (is_r_alu || is_i_alu) begin
                        aluop     = alu_fn;
                        alu_src_b = src_b_sel;
                    end else if (is_lw || is_sw) begin
                        aluop     = AluAdd;
                        alu_src_b = SrcSext;
                    end else if (is_beq || is_bne) begin
                        aluop    = AluSub;
                        pc_src   = PcBranch;
                        pc_write = is_beq ? alu_zero : ~alu_zero;
                    end else if (is_j) begin
                        pc_write = 1'b1;
                        pc_src   = PcJump;
                    end else if (is_jr) begin
                        pc_write = 1'b1;
                        pc_src   = PcRs;
                    end else if (is_jal) begin
                        pc_write  = 1'b1;
                        pc_src    = PcJump;
                        reg_write = 1'b1;
                        reg_dst   = DstRa;
                        wb_sel    = WbLink;
                    end
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                end
                StWb: begin
                    reg_write = 1'b1;
                    if (is_lw) begin
                        wb_sel  = WbMem;
                        reg_dst = DstRt;
                    end else if (is_r_alu) begin
                        wb_sel  = WbAlu;
                        reg_dst = DstRd;
                    end else begin
                        wb_sel  = WbAlu;
                        reg_dst = DstRt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir      = ir_q;
    assign bus_err = bus_err_q;
    assign illegal = illegal_q;
    assign state   = rst ? 3'd0 : state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle successor to the single-cycle instruction decoder: the same MIPS opcode decode, sequenced over IF/ID/EX/MEM/WB states by an FSM.
- Owns the instruction register and drives per-state datapath controls.
- Runs a req/ready handshake to instruction and data memory, with a parametrised wait timeout and optional illegal-instruction trap.
- Sits between the memory interfaces and the shared register file/ALU datapath.

Parameters:
MEM_TIMEOUT, 64, max cycles a req may wait for ready before bus error (must be ≥1).
TO_W, 8, timeout counter width (must satisfy 2^TO_W > MEM_TIMEOUT).
EXC_EN, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode retires as NOP.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
imem_rdata  in  32  instruction word, valid when imem_ready=1.
imem_ready  in  1  instruction fetch complete.
dmem_ready  in  1  data access complete.
alu_zero  in  1  ALU result == 0.
imem_req  out  1  fetch request.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store.
ir  out  32  latched instruction.
pc_write  out  1  PC load enable.
pc_src  out  2  0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs.
aluop  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LUI.
alu_src_b  out  2  0 = rt, 1 = sign-ext imm, 2 = zero-ext imm.
reg_write  out  1  register-file write enable.
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
wb_sel  out  2  0 = ALU, 1 = mem data, 2 = pc+4.
bus_err  out  1  sticky memory timeout flag.
illegal  out  1  sticky illegal-opcode flag.
state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=5, TRAP=6.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state←IF, ir←0, timeout counter←0, bus_err←0, illegal←0.
  - While rst=1, all other outputs are forced to 0.
- All outputs other than ir, bus_err and illegal decode combinationally from state and ir.
- Supported set:
  - R-type: addu, subu, and, or, slt, jr.
  - I-type and jumps: addiu, ori, lui, lw, sw, beq, bne, j, jal.
  - ir==0 is a NOP.
- IF:
  - imem_req=1.
  - On imem_ready: ir←imem_rdata, pc_write=1, pc_src=0, next state ID.
- ID (1 cycle), next state by instruction:
  - NOP → IF.
  - Illegal opcode/funct → TRAP if EXC_EN=1, else IF.
  - Everything else → EX.
- EX (1 cycle), ALU instructions:
  - R-type: alu_src_b=0.
  - addiu / lui: alu_src_b=1.
  - ori: alu_src_b=2.
  - Next state WB.
- EX, memory instructions (lw/sw):
  - aluop=ADD, alu_src_b=1, next state MEM.
- EX, branches:
  - beq: aluop=SUB, pc_write=alu_zero, pc_src=1, next state IF.
  - bne: aluop=SUB, pc_write=~alu_zero, pc_src=1, next state IF.
- EX, jumps (next state IF):
  - j: pc_write=1, pc_src=2.
  - jr: pc_write=1, pc_src=3.
  - jal: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_sel=2.
- MEM:
  - dmem_req=1, dmem_we=(op==sw).
  - On dmem_ready: lw → WB, sw → IF.
- WB (1 cycle), reg_write=1:
  - lw: wb_sel=1, reg_dst=0.
  - R-type: wb_sel=0, reg_dst=1.
  - I-type: wb_sel=0, reg_dst=0.
  - Next state IF.
- Latency with zero-wait memory:
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches/jumps: 3 cycles.
- Handshake:
  - req is held high until ready; ready is ignored when req=0.
  - ready is accepted in the same cycle it is seen; no combinational path from ready to req.
- Timeout:
  - Counter clears on entering IF/MEM and increments each cycle req=1 && ready=0.
  - When the counter reaches MEM_TIMEOUT with ready still 0: state→ERR, bus_err←1.
  - Ready arriving in the same cycle the count hits MEM_TIMEOUT wins: normal transition, no error.
- ERR and TRAP:
  - Both are absorbing; only rst exits.
  - All reqs and write enables are 0.
  - TRAP sets illegal←1.
- Reset mid-access: state returns to IF at that edge; req drops while rst=1; no write enable is asserted.

Test Plan:
- Zero-wait addu (op 0, funct 0x21) → states IF,ID,EX,WB,IF; reg_write=1 only in WB with reg_dst=1, wb_sel=0; 4 cycles.
- lw with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=1; total 8 cycles.
- beq with alu_zero=1, then again with alu_zero=0 → pc_write=1/pc_src=1 in EX for the first, pc_write=0 for the second; both return to IF.
- jal → in EX pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_sel=2; next state IF.
- MEM_TIMEOUT=4, imem_ready never asserted → ERR after 4 waiting cycles, bus_err=1, imem_req=0; imem_ready at count 4 instead → no error.
- Opcode 0x3F with EXC_EN=1 → TRAP, illegal=1; with EXC_EN=0 → back to IF with no side effects; rst pulse in MEM clears state/flags to IF/0.
